// File: rtl/alu_seq_if.sv
// Request/response bundle between the multi-cycle controller and alu_seq.
// The controller holds the master side; the ALU holds the slave side.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result2;
    logic [3:0]       ALUFlags;
    logic             busy;
    logic             done;
    logic             divzero;

    modport master (
        output start, ALUControl, a, b,
        input  Result, Result2, ALUFlags, busy, done, divzero
    );

    modport slave (
        input  start, ALUControl, a, b,
        output Result, Result2, ALUFlags, busy, done, divzero
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: one-cycle add/sub/logic, iterative shift-add multiply and
// restoring divide, driven through a start/done handshake. Flags are {N,Z,C,V}.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;
    logic   accept;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result2_q;
    logic [3:0]       flags_q;
    logic             divzero_q;

    // Request decode and single-cycle datapath, evaluated on the live inputs
    logic             iter_start;
    logic             in_smull;
    logic             in_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_res2;
    logic             sc_c;
    logic             sc_v;
    logic             sc_dz;
    logic [3:0]       sc_flags;

    always_comb begin
        in_smull   = (bus.ALUControl == 3'b110);
        in_div     = (bus.ALUControl == 3'b111);
        iter_start = bus.ALUControl[2] && !(in_div && (bus.b == '0));
        a_mag      = (in_smull && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag      = (in_smull && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        bx  = bus.ALUControl[0] ? ~bus.b : bus.b;
        sum = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, bus.ALUControl[0]};

        sc_res  = '0;
        sc_res2 = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_dz   = 1'b0;
        case (bus.ALUControl)
            3'b000, 3'b001: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = ~(bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ bus.ALUControl[0])
                         & (bus.a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            3'b010: sc_res = bus.a & bus.b;
            3'b011: sc_res = bus.a | bus.b;
            3'b111: begin
                sc_res  = '1;
                sc_res2 = bus.a;
                sc_dz   = 1'b1;
            end
            default: ;
        endcase
        sc_flags = {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
    end

    // One iteration of multiply or divide; both share the 2*WIDTH register
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_raw;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] step_next;
    logic               long_q;
    logic [3:0]         it_flags;

    always_comb begin
        mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_raw  = {mul_add, prod_q[WIDTH-1:1]};
        mul_next = (op_q == 3'b110 && neg_q && cnt_q == '0) ? -mul_raw : mul_raw;

        // High half holds the partial remainder, low half shifts dividend out / quotient in
        shifted  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor_q};
        qbit     = ~diff[WIDTH];
        rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

        step_next = (op_q == 3'b111) ? {rem_next, prod_q[WIDTH-2:0], qbit} : mul_next;

        long_q   = (op_q == 3'b101) || (op_q == 3'b110);
        it_flags = long_q ? {step_next[2*WIDTH-1], (step_next == '0), 2'b00}
                          : {step_next[WIDTH-1], (step_next[WIDTH-1:0] == '0), 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = iter_start ? RUN : DONE;
                end
            end
            RUN: if (cnt_q == '0) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            mcand_q   <= '0;
            divisor_q <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            result2_q <= '0;
            flags_q   <= '0;
            divzero_q <= 1'b0;
        end else if (accept) begin
            op_q      <= bus.ALUControl;
            mcand_q   <= a_mag;
            divisor_q <= bus.b;
            prod_q    <= {{WIDTH{1'b0}}, (in_div ? bus.a : b_mag)};
            cnt_q     <= CW'(WIDTH - 1);
            neg_q     <= in_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            if (!iter_start) begin
                result_q  <= sc_res;
                result2_q <= sc_res2;
                flags_q   <= sc_flags;
                divzero_q <= sc_dz;
            end
        end else if (state == RUN) begin
            prod_q <= step_next;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
                result_q  <= step_next[WIDTH-1:0];
                result2_q <= step_next[2*WIDTH-1:WIDTH];
                flags_q   <= it_flags;
                divzero_q <= 1'b0;
            end
        end
    end

    assign bus.Result   = result_q;
    assign bus.Result2  = result2_q;
    assign bus.ALUFlags = flags_q;
    assign bus.divzero  = divzero_q;
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq: the driver pushes expected responses from an
// arithmetic reference model; a negedge monitor pops and compares on done.
module tb_alu_seq;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] res2;
        logic [3:0]  fl;
        logic        dz;
        int          lat;
        int          acc;
        int          dn;
    } exp_t;

    exp_t q[$];
    exp_t last;
    exp_t mh;
    logic meb;
    int   cyc  = 0;
    int   vecs = 0;
    int   errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, got, want);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, r;
        longint unsigned p;
        e = '{default: 0};
        e.lat = 1;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0, 3'd1: begin
                r = op[0] ? sa - sb : sa + sb;
                e.res   = r[31:0];
                e.fl[1] = op[0] ? (a >= b) : ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
                e.fl[0] = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4, 3'd5: begin
                p = 64'(a) * 64'(b);
                e.res  = p[31:0];
                e.res2 = p[63:32];
                e.lat  = 33;
            end
            3'd6: begin
                r = sa * sb;
                e.res  = r[31:0];
                e.res2 = r[63:32];
                e.lat  = 33;
            end
            default: begin
                if (b == 0) begin
                    e.res  = 32'hFFFF_FFFF;
                    e.res2 = a;
                    e.dz   = 1'b1;
                end else begin
                    e.res  = a / b;
                    e.res2 = a % b;
                    e.lat  = 33;
                end
            end
        endcase
        if (op == 3'd5 || op == 3'd6) begin
            e.fl[3] = e.res2[31];
            e.fl[2] = ({e.res2, e.res} == 64'd0);
        end else begin
            e.fl[3] = e.res[31];
            e.fl[2] = (e.res == 32'd0);
        end
        return e;
    endfunction

    // While the DUT is busy the request lines are scrambled to show they are ignored
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 100) begin
            bus.start      = 1'($urandom_range(0, 1));
            bus.ALUControl = 3'($urandom);
            bus.a          = $urandom;
            bus.b          = $urandom;
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) begin
            errs++;
            vecs++;
            $display("FAIL busy_timeout at cycle %0d: got busy=1 want busy=0", cyc);
        end
        e = model(op, a, b);
        n = cyc;
        e.acc = n + 1;
        e.dn  = n + e.lat;
        bus.start      = 1'b1;
        bus.ALUControl = op;
        bus.a          = a;
        bus.b          = b;
        @(posedge clk);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.start      = 1'b0;
            bus.ALUControl = 3'($urandom);
            bus.a          = $urandom;
            bus.b          = $urandom;
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk_zero_state(input string tag);
        chk({tag, "_result"},  {32'd0, bus.Result},  64'd0);
        chk({tag, "_result2"}, {32'd0, bus.Result2}, 64'd0);
        chk({tag, "_flags"},   {60'd0, bus.ALUFlags}, 64'd0);
        chk({tag, "_busy"},    {63'd0, bus.busy},    64'd0);
        chk({tag, "_done"},    {63'd0, bus.done},    64'd0);
        chk({tag, "_divzero"}, {63'd0, bus.divzero}, 64'd0);
    endtask

    // Response monitor: busy window, done latency, result values, and hold between completions
    always @(negedge clk) begin
        meb = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].dn);
        chk("busy", {63'd0, bus.busy}, {63'd0, meb});
        if (bus.done) begin
            if (q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_done at cycle %0d: got done=1 want done=0", cyc);
            end else begin
                mh = q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mh.dn));
                chk("result",  {32'd0, bus.Result},  {32'd0, mh.res});
                chk("result2", {32'd0, bus.Result2}, {32'd0, mh.res2});
                chk("flags",   {60'd0, bus.ALUFlags}, {60'd0, mh.fl});
                chk("divzero", {63'd0, bus.divzero}, {63'd0, mh.dz});
                last = mh;
            end
        end else begin
            if (q.size() > 0 && cyc >= q[0].dn) begin
                vecs++;
                errs++;
                $display("FAIL done_missing at cycle %0d: got done=0 want done=1 at cycle %0d", cyc, q[0].dn);
                void'(q.pop_front());
            end
            chk("hold_result", {bus.Result2, bus.Result}, {last.res2, last.res});
            chk("hold_flags", {59'd0, bus.divzero, bus.ALUFlags}, {59'd0, last.dz, last.fl});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d: got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        last = '{default: 0};
        bus.start      = 1'b0;
        bus.ALUControl = 3'd0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_zero_state("reset");

        issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        idle(2);
        issue(3'd1, 32'd5, 32'd5);
        issue(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        idle(2);
        issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd6, 32'hFFFF_FFFE, 32'd3);
        idle(1);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd7, 32'h0000_1234, 32'd0);
        idle(1);
        issue(3'd4, 32'h8000_0000, 32'h8000_0000);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        // Back-to-back divides: the second request is accepted on the first done edge
        issue(3'd7, 32'd1000, 32'd3);
        issue(3'd7, 32'hFFFF_FFFF, 32'd16);
        idle(2);

        // Reset on edge 10 of a long multiply, together with a start that must lose
        issue(3'd5, $urandom, $urandom);
        repeat (10) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = $urandom;
        end
        reset          = 1'b1;
        bus.start      = 1'b1;
        bus.ALUControl = 3'd0;
        bus.a          = 32'd1;
        bus.b          = 32'd1;
        @(posedge clk);
        q.delete();
        last = '{default: 0};
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk_zero_state("abort");
        idle(40);
        issue(3'd0, 32'd10, 32'd20);
        idle(2);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            issue(op, rnd_operand(), rnd_operand());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            vecs++;
            errs++;
            $display("FAIL drain at cycle %0d: got %0d pending want 0", cyc, q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
